// File: rtl/bcd33_generator.sv
// Streams ascending BCD multiples of 33, starting at the first multiple >= a loaded seed.
// Wraps to zero on decimal overflow; residue tracks value mod 33 so the search needs no divider.
//
// state  | meaning
// IDLE   | waiting for a seed, load_ready high
// SEARCH | stepping value by +1 until residue reaches 0
// EMIT   | presenting multiples of 33 on the valid/ready output
module bcd33_generator #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_bcd,
    input  logic                  stop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_last,
    output logic                  err,
    output logic                  busy
);
    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] BCD_ONE = W'(4'h1);
    localparam logic [W-1:0] BCD_33  = W'(8'h33);

    typedef enum logic [1:0] {IDLE, SEARCH, EMIT} state_t;

    state_t       state, state_d;
    logic [W-1:0] value, value_d;
    logic [5:0]   residue, residue_d;
    logic         err_q, err_d;
    logic [W:0]   inc_sum, add33_sum;
    logic         seed_ok;
    logic [5:0]   seed_res;

    // Digit-serial decimal add; bit W of the result is the carry out of the top digit.
    function automatic logic [W:0] bcd_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] s;
        logic         c;
        logic [4:0]   d;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
            if (d > 5'd9) begin
                d = d + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            s[4*i +: 4] = d[3:0];
        end
        return {c, s};
    endfunction

    // 100 == 1 (mod 33), so digit pairs fold into even + 10*odd before reduction.
    function automatic logic [5:0] seed_residue(input logic [W-1:0] v);
        logic [8:0] ev, od, t;
        ev = '0;
        od = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (i % 2 == 0) ev = ev + 9'(v[4*i +: 4]);
            else            od = od + 9'(v[4*i +: 4]);
        end
        t = ev + (od << 3) + (od << 1);
        if (t >= 9'd264) t = t - 9'd264;
        if (t >= 9'd132) t = t - 9'd132;
        if (t >= 9'd66)  t = t - 9'd66;
        if (t >= 9'd33)  t = t - 9'd33;
        return 6'(t);
    endfunction

    always_comb begin
        seed_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_bcd[4*i +: 4] > 4'd9) seed_ok = 1'b0;
        end
    end

    assign seed_res  = seed_residue(load_bcd);
    assign inc_sum   = bcd_add(value, BCD_ONE);
    assign add33_sum = bcd_add(value, BCD_33);

    always_comb begin
        state_d   = state;
        value_d   = value;
        residue_d = residue;
        err_d     = 1'b0;
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        if (seed_ok) begin
                            value_d   = load_bcd;
                            residue_d = seed_res;
                            state_d   = SEARCH;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                SEARCH: begin
                    if (residue == 6'd0) begin
                        state_d = EMIT;
                    end else if (inc_sum[W]) begin
                        value_d   = '0;
                        residue_d = '0;
                        state_d   = EMIT;
                    end else begin
                        value_d   = inc_sum[W-1:0];
                        residue_d = (residue == 6'd32) ? 6'd0 : residue + 6'd1;
                    end
                end
                EMIT: begin
                    if (out_ready) value_d = add33_sum[W] ? '0 : add33_sum[W-1:0];
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            value   <= '0;
            residue <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            value   <= value_d;
            residue <= residue_d;
            err_q   <= err_d;
        end
    end

    assign load_ready = (state == IDLE);
    assign out_valid  = (state == EMIT);
    assign out_last   = out_valid && add33_sum[W];
    assign out_bcd    = value;
    assign err        = err_q;
    assign busy       = (state != IDLE);
endmodule

// File: tb/tb_bcd33_generator.sv
// Directed bench for bcd33_generator (DIGITS = 4): expected stream values are queued
// at load time and popped as the DUT hands each one over.
module tb_bcd33_generator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_bcd = '0;
    logic        stop = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_bcd;
    logic        out_last;
    logic        err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] bcd;
        logic        last;
    } exp_t;
    exp_t sb[$];

    bcd33_generator #(.DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_ready(load_ready), .load_bcd(load_bcd),
        .stop(stop),
        .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd), .out_last(out_last),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] bcd, input logic last);
        exp_t e;
        e.bcd  = bcd;
        e.last = last;
        sb.push_back(e);
    endtask

    // Leaves the bench at the first negedge after the load edge.
    task automatic do_load(input logic [15:0] seed);
        @(negedge clk);
        load_bcd   = seed;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_k);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, 32'(cyc), 32'(exp_k));
    endtask

    task automatic expect_stream(input string tag, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            if (sb.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk({tag, "_bcd"}, 32'(out_bcd), 32'(e.bcd));
                chk({tag, "_last"}, 32'(out_last), 32'(e.last));
            end
        end
    endtask

    task automatic stop_pulse();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        // 1: reset
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_bcd", 32'(out_bcd), 32'h0000);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd1);
        chk("rst_err", 32'(err), 32'd0);

        // 2: seed 0x0100 -> 0x0132 after 33 cycles, then back-to-back stream
        out_ready = 1'b1;
        push(16'h0132, 1'b0);
        push(16'h0165, 1'b0);
        push(16'h0198, 1'b0);
        push(16'h0231, 1'b0);
        do_load(16'h0100);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_ldrdy", 32'(load_ready), 32'd0);
        wait_valid("t2_latency", 33);
        expect_stream("t2", 4);
        stop_pulse();

        // 3: seed 0x9990 -> 0x9999 (last), wrap to 0x0000, then 0x0033
        push(16'h9999, 1'b1);
        push(16'h0000, 1'b0);
        push(16'h0033, 1'b0);
        do_load(16'h9990);
        wait_valid("t3_latency", 10);
        expect_stream("t3", 3);
        stop_pulse();
        chk("t3_stop_valid", 32'(out_valid), 32'd0);

        // 4: seed 0x0000 with backpressure, then a single handshake
        out_ready = 1'b0;
        do_load(16'h0000);
        wait_valid("t4_latency", 1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_bcd", 32'(out_bcd), 32'h0000);
            @(negedge clk);
        end
        push(16'h0000, 1'b0);
        push(16'h0033, 1'b0);
        expect_stream("t4_pre", 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        expect_stream("t4_post", 1);
        @(negedge clk);
        chk("t4_held_bcd", 32'(out_bcd), 32'h0033);
        @(negedge clk);
        chk("t4_held_bcd2", 32'(out_bcd), 32'h0033);
        stop_pulse();

        // 5: seed with a non-decimal digit
        @(negedge clk);
        load_bcd   = 16'h12A4;
        load_valid = 1'b1;
        @(negedge clk);
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ldrdy", 32'(load_ready), 32'd1);
        chk("t5_valid", 32'(out_valid), 32'd0);
        load_valid = 1'b0;
        @(negedge clk);
        chk("t5_err_pulse", 32'(err), 32'd0);
        chk("t5_valid2", 32'(out_valid), 32'd0);

        // 6: stop mid-search retains value, then async reset mid-emit
        out_ready = 1'b1;
        do_load(16'h0100);
        repeat (4) @(negedge clk);
        chk("t6_search_busy", 32'(busy), 32'd1);
        chk("t6_search_valid", 32'(out_valid), 32'd0);
        stop = 1'b1;
        load_valid = 1'b1;
        load_bcd = 16'h0000;
        @(negedge clk);
        stop = 1'b0;
        load_valid = 1'b0;
        chk("t6_stop_busy", 32'(busy), 32'd0);
        chk("t6_stop_valid", 32'(out_valid), 32'd0);
        chk("t6_stop_ldrdy", 32'(load_ready), 32'd1);
        chk("t6_stop_value", 32'(out_bcd), 32'h0104);
        do_load(16'h0100);
        wait_valid("t6_latency", 33);
        @(negedge clk);
        chk("t6_emit_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_arst_valid", 32'(out_valid), 32'd0);
        chk("t6_arst_bcd", 32'(out_bcd), 32'h0000);
        chk("t6_arst_last", 32'(out_last), 32'd0);
        chk("t6_arst_busy", 32'(busy), 32'd0);
        chk("t6_arst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_ldrdy", 32'(load_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bcd33_generator.md
Name: bcd33_generator

Overview:
- Produces, in ascending order, the BCD numbers that are divisible by 33 (divisible by both 3 and 11). It is the source-side counterpart of the divisible-by-33 BCD checker.
- A BCD seed is loaded. The block searches upward to the first multiple of 33 that is ≥ the seed, then streams successive multiples on a valid/ready output.
- It wraps to zero on decimal overflow. Its output feeds checker benches and downstream BCD datapaths.

Parameters:
- DIGITS, 4: number of BCD digits. Supported range is 2..6. Data width W = 4*DIGITS.

Ports:
- clk  in  1  clock, all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- load_valid  in  1  seed offered
- load_ready  out  1  seed accepted when load_valid && load_ready
- load_bcd  in  W  seed value, BCD, digit 0 in [3:0]
- stop  in  1  synchronous abort back to IDLE
- out_valid  out  1  out_bcd holds a multiple of 33
- out_ready  in  1  consumer accepts
- out_bcd  out  W  current multiple, BCD
- out_last  out  1  out_bcd + 33 overflows DIGITS digits; valid only with out_valid
- err  out  1  one-cycle pulse: rejected seed contained a digit > 9
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, value = 0, residue = 0.
  - out_valid = 0, out_bcd = 0, out_last = 0, err = 0, busy = 0.
  - load_ready = 1 once rst_n is high, because IDLE.
- Registers:
  - value: W bits of BCD.
  - residue: 6 bits, range 0..32, always equal to value mod 33.
  - state: IDLE, SEARCH or EMIT.
  - out_bcd = value.
- Residue at load: residue = (sum of even-index digits + 10 * sum of odd-index digits) mod 33. This holds because 100 ≡ 1 (mod 33). It is computed combinationally from load_bcd and registered on the load edge.
- IDLE:
  - load_ready = 1.
  - On a load handshake with all digits ≤ 9: value ← load_bcd, residue ← computed residue, go to SEARCH.
  - On a load handshake with any digit > 9: err = 1 for one cycle, nothing else changes, stay in IDLE.
- SEARCH (one decision per cycle):
  - residue == 0: go to EMIT.
  - residue != 0, no carry out: value ← BCD(value + 1), residue ← (residue + 1) mod 33.
  - The +1 carries out of the top digit: value ← 0, residue ← 0, go to EMIT.
  - out_valid = 0 throughout SEARCH.
- Latency: with k = (33 − r) mod 33 and no overflow, out_valid rises k + 1 cycles after the load edge.
- EMIT:
  - out_valid = 1.
  - out_last = 1 iff the BCD add value + 33 carries out of the top digit.
  - out_bcd and out_last hold stable while out_ready = 0.
  - On handshake: value ← BCD(value + 33) and stay in EMIT, so back-to-back handshakes give one value per cycle.
  - If the add carried out, value ← 0 instead (0 is a multiple), residue stays 0, and the block keeps streaming.
- BCD add: per-digit binary add, then +6 correction when the digit sum > 9, with the decimal carry rippling through all DIGITS digits. No binary arithmetic is allowed on the packed word.
- stop:
  - In any state, the next state is IDLE and out_valid is 0 from the following cycle.
  - value is retained.
  - stop has priority over both handshakes in the same cycle; a load offered together with stop is not accepted.
- Loads are ignored outside IDLE, because load_ready = 0 there.
- Async reset mid-SEARCH or mid-EMIT returns immediately to the reset values.

Test Plan (DIGITS = 4):
1. Assert rst_n low, then release → out_valid=0, out_bcd=0x0000, out_last=0, busy=0, load_ready=1.
2. Load 0x0100 (residue 1, k=32), hold out_ready=1 → out_valid rises 33 cycles after the load edge with 0x0132. Then one value per cycle: 0x0165, 0x0198, 0x0231.
3. Load 0x9990 (residue 24, k=9) → first output 0x9999 with out_last=1. Then 0x0000 with out_last=0, then 0x0033.
4. Load 0x0000 (k=0), hold out_ready=0 for 5 cycles once 0x0000 is shown → value and out_valid stay stable. Then pulse out_ready for one cycle → 0x0033, held.
5. Load 0x12A4 → err high for exactly one cycle, state stays IDLE, load_ready=1, and no output.
6. Assert stop during SEARCH of seed 0x0100 → IDLE next cycle with out_valid=0. Then drive rst_n low mid-EMIT → all outputs go to reset values immediately (asynchronously).
